// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer with req/ack instruction memory handshake (optional FETCH_PERF_EN counters)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        valid_F,
    output logic [31:0] pc_F,
    output logic [31:0] pc4_F,
    output logic [31:0] instr_F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_squash
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        drop_q, drop_d;

    logic        consume;
    logic        acc;
    logic        fire;
    logic        discard;
    logic        fill;

    // Decode-side events and response classification
    always_comb begin
        consume = valid_q & ~stall_D;
        acc     = redirect & ~stall_D;
        fire    = im_req & im_ack;
        discard = fire & (drop_q | acc);
        fill    = fire & ~discard;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: an unacknowledged request parks in S_WAIT until its ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (im_req && !im_ack) state_d = S_WAIT;
            S_WAIT:  if (im_ack) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs: the address of an outstanding request comes from its own latch so a redirect cannot disturb it
    always_comb begin
        im_req  = 1'b0;
        im_addr = fpc_q;
        case (state_q)
            S_FETCH: im_req = ~valid_q | ~stall_D;
            S_WAIT: begin
                im_req  = 1'b1;
                im_addr = req_addr_q;
            end
            default: im_req = 1'b0;
        endcase
    end

    // Datapath next values: fetch pc, slot contents, wrong-path drop flag
    always_comb begin
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        drop_d     = drop_q;

        if (state_q == S_FETCH && im_req && !im_ack) begin
            req_addr_d = im_addr;
        end

        if (acc) begin
            fpc_d = redirect_pc;
        end else if (fill) begin
            fpc_d = im_addr + PC_STEP;
        end

        if (fire) begin
            drop_d = 1'b0;
        end else if (acc && im_req) begin
            drop_d = 1'b1;
        end

        if (acc) begin
            valid_d = 1'b0;
        end else if (fill) begin
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        if (fill) begin
            pc_d    = im_addr;
            instr_d = im_rdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            drop_q     <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            drop_q     <= drop_d;
        end
    end

    assign valid_F = valid_q;
    assign pc_F    = pc_q;
    assign pc4_F   = pc_q + PC_STEP;
    assign instr_F = instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_squash_q;
    logic [31:0] squash_inc;

    // A squashed valid slot and a discarded response can coincide; both count
    always_comb begin
        squash_inc = {31'd0, discard} + {31'd0, acc & valid_q};
    end

    // Event counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_q  <= 32'd0;
            perf_squash_q <= 32'd0;
        end else begin
            perf_fetch_q  <= perf_fetch_q + {31'd0, fill};
            perf_squash_q <= perf_squash_q + squash_inc;
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_squash = perf_squash_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_D;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        valid_F;
    logic [31:0] pc_F;
    logic [31:0] pc4_F;
    logic [31:0] instr_F;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_squash;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall_D     (stall_D),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .valid_F     (valid_F),
        .pc_F        (pc_F),
        .pc4_F       (pc4_F),
        .instr_F     (instr_F)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_squash (perf_squash)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, valid_F}, 32'd1);
            chk({tag, "_pc"}, pc_F, e);
            chk({tag, "_instr"}, instr_F, mem(e));
            chk({tag, "_pc4"}, pc4_F, e + 32'd4);
        end
    endtask

    // One memory transaction of lat cycles, the ack landing on the last cycle
    task automatic mem_xact(input string tag, input logic [31:0] addr, input int lat);
        for (int c = 0; c < lat; c++) begin
            im_ack = (c == lat - 1);
            #2;
            im_rdata = mem(im_addr);
            chk({tag, "_req"}, {31'd0, im_req}, 32'd1);
            chk({tag, "_addr"}, im_addr, addr);
            if (c == lat - 1) sb_q.push_back(addr);
            tick();
            if (c < lat - 1) chk({tag, "_wait_valid"}, {31'd0, valid_F}, 32'd0);
        end
        im_ack = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        reset       = 1'b0;
        stall_D     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        im_ack      = 1'b0;
        im_rdata    = 32'd0;
        repeat (3) tick();

        // reset state
        chk("rst_valid", {31'd0, valid_F}, 32'd0);
        chk("rst_pc", pc_F, 32'h3000);
        chk("rst_pc4", pc4_F, 32'h3004);
        chk("rst_instr", instr_F, 32'd0);
        chk("rst_req", {31'd0, im_req}, 32'd0);

        // release: one boot cycle without a request
        reset = 1'b1;
        #2;
        chk("boot_req", {31'd0, im_req}, 32'd0);
        tick();

        // zero-wait memory, one instruction per cycle
        mem_xact("zw0", 32'h3000, 1);
        mem_xact("zw1", 32'h3004, 1);
        mem_xact("zw2", 32'h3008, 1);

        // three-cycle latency
        mem_xact("lat0", 32'h300C, 3);
        mem_xact("lat1", 32'h3010, 3);

        // decode stall holds the slot and suppresses requests
        stall_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("stall_req", {31'd0, im_req}, 32'd0);
            tick();
            chk("stall_valid", {31'd0, valid_F}, 32'd1);
            chk("stall_pc", pc_F, 32'h3010);
            chk("stall_instr", instr_F, mem(32'h3010));
        end
        stall_D = 1'b0;
        mem_xact("unstall", 32'h3014, 1);

        // redirect while a request is outstanding: response dropped
        #2;
        chk("rd_req0", {31'd0, im_req}, 32'd1);
        chk("rd_addr0", im_addr, 32'h3018);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        #2;
        chk("rd_addr1", im_addr, 32'h3018);
        tick();
        redirect = 1'b0;
        im_ack   = 1'b1;
        #2;
        im_rdata = mem(im_addr);
        chk("rd_req2", {31'd0, im_req}, 32'd1);
        chk("rd_addr2", im_addr, 32'h3018);
        tick();
        im_ack = 1'b0;
        chk("rd_dropped", {31'd0, valid_F}, 32'd0);
        mem_xact("tgt0", 32'h3100, 1);
        mem_xact("tgt1", 32'h3104, 1);

        // redirect under stall is ignored, then taken once the stall drops
        stall_D     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("rs_req", {31'd0, im_req}, 32'd0);
            tick();
            chk("rs_valid", {31'd0, valid_F}, 32'd1);
            chk("rs_pc", pc_F, 32'h3104);
        end
        stall_D = 1'b0;
        im_ack  = 1'b1;
        #2;
        im_rdata = mem(im_addr);
        chk("rs_addr", im_addr, 32'h3108);
        tick();
        redirect = 1'b0;
        im_ack   = 1'b0;
        chk("rs_squash", {31'd0, valid_F}, 32'd0);
        mem_xact("rs_tgt", 32'h3200, 1);

`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch, 32'd9);
        chk("perf_squash", perf_squash, 32'd3);
`endif

        // reset in the middle of an outstanding request
        #2;
        chk("mr_addr", im_addr, 32'h3204);
        tick();
        reset = 1'b0;
        tick();
        chk("mr_req", {31'd0, im_req}, 32'd0);
        chk("mr_valid", {31'd0, valid_F}, 32'd0);
        chk("mr_pc", pc_F, 32'h3000);
        chk("mr_instr", instr_F, 32'd0);
`ifdef FETCH_PERF_EN
        chk("mr_perf_fetch", perf_fetch, 32'd0);
        chk("mr_perf_squash", perf_squash, 32'd0);
`endif
        reset    = 1'b1;
        im_ack   = 1'b1;
        im_rdata = 32'hBAD0_BAD0;
        #2;
        chk("late_req", {31'd0, im_req}, 32'd0);
        tick();
        im_ack = 1'b0;
        chk("late_valid", {31'd0, valid_F}, 32'd0);
        chk("late_instr", instr_F, 32'd0);
        mem_xact("restart", 32'h3000, 1);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer for the pipelined MIPS core.
- Owns the fetch PC and drives a request/acknowledge handshake to a variable-latency instruction memory.
- Presents one instruction at a time to the F/D pipeline register.
- Applies decode-stage stalls and taken branch/jump redirects, and discards wrong-path memory responses.
- Replaces the fixed PC register + PC+4 mux arrangement when instruction memory is not single-cycle.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
stall_D  in  1  decode stall; F/D holds, no consume
redirect  in  1  taken branch/jump resolved in D (NPCOp nonzero)
redirect_pc  in  32  redirect target, meaningful when redirect=1
im_req  out  1  instruction memory request
im_addr  out  32  request address, word aligned
im_ack  in  1  memory accepts and returns data this cycle
im_rdata  in  32  instruction word, valid when im_ack=1
valid_F  out  1  instr_F/pc_F hold a valid instruction
pc_F  out  32  address of instr_F
pc4_F  out  32  pc_F + PC_STEP
instr_F  out  32  fetched instruction

Behaviour:
- Reset (reset=0 at an edge): state=S_BOOT, fetch pc=RESET_PC, valid_F=0, pc_F=RESET_PC, instr_F=0, drop=0, im_req=0. Reset overrides everything, including an outstanding request. Any im_ack arriving while in S_BOOT is ignored.
- Consume event: consume = valid_F & ~stall_D. On a consume edge the F/D register takes instr_F.
- Accepted redirect: acc = redirect & ~stall_D. There is no branch delay slot. On acc:
  - valid_F <= 0 (squash the F instruction), and this takes priority over a same-cycle fill.
  - fetch pc <= redirect_pc.
- States:
  - S_BOOT: im_req=0. Next edge goes to S_FETCH.
  - S_FETCH: im_req = ~valid_F | ~stall_D, i.e. the output slot is empty or is being freed this cycle. im_addr = fetch pc.
  - S_WAIT: im_req=1, im_addr held. Entered when im_req=1 and im_ack=0. Returns to S_FETCH on im_ack.
- Handshake rules:
  - Once im_req=1 without ack, im_req and im_addr stay stable until im_ack. The memory may ack in the same cycle as the request (zero-wait).
  - Redirects and stalls never change im_addr mid-request.
- Response handling on an edge with im_req & im_ack:
  - Discard the response if drop=1 or acc=1 this cycle. valid_F stays/becomes 0. drop <= 0. Fetch pc = redirect target (captured earlier or now).
  - Otherwise: instr_F <= im_rdata, pc_F <= im_addr, valid_F <= 1, fetch pc <= im_addr + PC_STEP (32-bit wrap, no trap).
- Redirect while the request is outstanding (acc=1 in S_WAIT with im_ack=0): drop <= 1. The target is stored in fetch pc and is issued after the pending ack.
- Slot management:
  - consume without fill: valid_F <= 0.
  - fill with consume in the same cycle: the new instruction replaces the old one, for full throughput of one instr/cycle at zero-wait.
- Hold conditions:
  - stall_D=1 with valid_F=1: no new request in S_FETCH; valid_F/instr_F/pc_F hold.
  - A redirect with stall_D=1 is ignored; the D stage must hold it.
- pc4_F is always pc_F + PC_STEP (combinational).
- Fetch pc is never written while im_req=1 & ~im_ack, except through a redirect, which is stored for later issue (the next im_addr) rather than applied to the outstanding request.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch[31:0] and perf_squash[31:0].
  - perf_fetch counts accepted (non-discarded) fills.
  - perf_squash counts discarded responses plus redirects that clear valid_F=1.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset, then zero-wait memory with ack=req and no stall -> im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_F=1 from the 2nd cycle after reset release; pc4_F=pc_F+4.
- 3-cycle memory latency -> im_addr 0x3000 held for 3 cycles with im_req=1; valid_F rises the edge after ack; one instr per 3 cycles.
- valid_F=1 and stall_D=1 for 4 cycles -> im_req=0, instr_F/pc_F unchanged; stall release -> request 0x3008 the same cycle.
- Redirect to 0x3100 issued while the request for 0x300C is pending 2 more cycles -> 0x300C data discarded (valid_F=0); next im_addr=0x3100; then 0x3104.
- Redirect with stall_D=1 -> ignored; the same redirect after stall drops -> valid_F cleared and fetch goes to the target.
- Reset asserted mid-request -> im_req=0 next cycle; late ack ignored; restart at 0x3000. With FETCH_PERF_EN defined, both counters read 0.
